// File: rtl/fdiv_issue_queue.sv
// Operand issue queue in front of the FP32 divider: buffers dividend/divisor pairs and
// issues the oldest one when the divider is free. Optional feature: FDIV_SPECIAL_BYPASS_EN.
module fdiv_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_d,
  input  logic [31:0]      in_e,
  output logic             div_start,
  output logic [31:0]      div_d,
  output logic [31:0]      div_e,
  input  logic             div_busy,
  input  logic             div_stall,
  output logic             byp_valid,
  output logic [31:0]      byp_q,
  output logic [PTR_W:0]   count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [31:0]    d_mem [DEPTH];
  logic [31:0]    e_mem [DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [1:0]     state, state_d;
  logic           full, empty, push, pop, issue_go, byp_go, head_special;
  logic [31:0]    head_d, head_e;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  // Same index with differing wrap bits means the buffer has lapped the reader.
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  assign head_d   = d_mem[rd_ptr[PTR_W-1:0]];
  assign head_e   = e_mem[rd_ptr[PTR_W-1:0]];

  assign issue_go  = (state == IDLE) && !empty && !head_special && !div_busy && !div_stall;
  assign byp_go    = (state == IDLE) && !empty && head_special;
  assign pop       = (state == ISSUE) || byp_go;
  assign div_start = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (push) begin
      d_mem[wr_ptr[PTR_W-1:0]] <= in_d;
      e_mem[wr_ptr[PTR_W-1:0]] <= in_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (issue_go) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (!div_busy && !div_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Head is stable through ISSUE, so operands are captured on the way in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      div_d <= '0;
      div_e <= '0;
    end else begin
      state <= state_d;
      if (issue_go) begin
        div_d <= head_d;
        div_e <= head_e;
      end
    end
  end

`ifdef FDIV_SPECIAL_BYPASS_EN
  logic        d_nan, d_inf, d_zero, e_nan, e_inf, e_zero, sgn;
  logic [31:0] byp_res;

  // Denormals have a zero exponent and are treated as zero.
  always_comb begin
    d_nan  = (&head_d[30:23]) && (|head_d[22:0]);
    d_inf  = (&head_d[30:23]) && !(|head_d[22:0]);
    d_zero = !(|head_d[30:23]);
    e_nan  = (&head_e[30:23]) && (|head_e[22:0]);
    e_inf  = (&head_e[30:23]) && !(|head_e[22:0]);
    e_zero = !(|head_e[30:23]);
    sgn    = head_d[31] ^ head_e[31];
    head_special = d_nan || d_inf || d_zero || e_nan || e_inf || e_zero;
    if (d_nan || e_nan || (d_zero && e_zero) || (d_inf && e_inf)) begin
      byp_res = 32'h7fc00000;
    end else if (d_inf || e_zero) begin
      byp_res = {sgn, 8'hff, 23'h0};
    end else begin
      byp_res = {sgn, 31'h0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_valid <= 1'b0;
      byp_q     <= '0;
    end else begin
      byp_valid <= byp_go;
      if (byp_go) byp_q <= byp_res;
    end
  end
`else
  assign head_special = 1'b0;
  assign byp_valid    = 1'b0;
  assign byp_q        = '0;
`endif

endmodule

// File: tb/tb_fdiv_issue_queue.sv
// Self-checking bench for fdiv_issue_queue: scoreboard of issued operand pairs and
// bypass quotients, checked in per-scenario tasks.
module tb_fdiv_issue_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_d = '0;
  logic [31:0]      in_e = '0;
  logic             div_start;
  logic [31:0]      div_d, div_e;
  logic             div_busy = 1'b0;
  logic             div_stall = 1'b0;
  logic             byp_valid;
  logic [31:0]      byp_q;
  logic [PTR_W:0]   count;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];

  fdiv_issue_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
    .in_e(in_e), .div_start(div_start), .div_d(div_d), .div_e(div_e),
    .div_busy(div_busy), .div_stall(div_stall), .byp_valid(byp_valid), .byp_q(byp_q),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count actual=%0d required=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
    checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL reset_div_start actual=%b required=0", div_start); end
    checks++; if (div_d !== 32'h0) begin failures++; $display("FAIL reset_div_d actual=%h required=0", div_d); end
    checks++; if (div_e !== 32'h0) begin failures++; $display("FAIL reset_div_e actual=%h required=0", div_e); end
    checks++; if (byp_valid !== 1'b0) begin failures++; $display("FAIL reset_byp_valid actual=%b required=0", byp_valid); end
    checks++; if (byp_q !== 32'h0) begin failures++; $display("FAIL reset_byp_q actual=%h required=0", byp_q); end
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL reset_state actual=%0d required=%0d", dut.state, ST_IDLE); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [63:0] exp;
    in_valid = 1'b1; in_d = 32'hc396d200; in_e = 32'hc0100000;
    sb.push_back({in_d, in_e});
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL single_early_start actual=%b required=0", div_start); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count actual=%0d required=1", count); end
    @(negedge clk);
    exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
    checks++; if (div_start !== 1'b1) begin failures++; $display("FAIL single_start actual=%b required=1", div_start); end
    checks++; if (div_d !== exp[63:32]) begin failures++; $display("FAIL single_div_d actual=%h required=%h", div_d, exp[63:32]); end
    checks++; if (div_e !== exp[31:0]) begin failures++; $display("FAIL single_div_e actual=%h required=%h", div_e, exp[31:0]); end
    @(negedge clk);
    checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL single_pulse_width actual=%b required=0", div_start); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_pop actual=%0d required=0", count); end
    repeat (2) tick();
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    bit found = 0;
    div_stall = 1'b1;
    in_valid = 1'b1; in_d = 32'h40ae0000; in_e = 32'hbec00000;
    sb.push_back({in_d, in_e});
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL stall_no_start cycle=%0d actual=%b required=0", c, div_start); end
    end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL stall_head_held actual=%0d required=1", count); end
    checks++; if (div_d !== 32'hc396d200) begin failures++; $display("FAIL stall_div_d_held actual=%h required=c396d200", div_d); end
    tick();
    div_stall = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      if (div_start === 1'b1) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL stall_issue actual=none required=div_start"); end
    exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
    checks++; if (div_d !== exp[63:32]) begin failures++; $display("FAIL stall_div_d actual=%h required=%h", div_d, exp[63:32]); end
    checks++; if (div_e !== exp[31:0]) begin failures++; $display("FAIL stall_div_e actual=%h required=%h", div_e, exp[31:0]); end
    // Stall rising right after issue must hold the FSM in WAIT.
    div_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (dut.state !== ST_WAIT) begin failures++; $display("FAIL stall_wait_hold actual=%0d required=%0d", dut.state, ST_WAIT); end
      checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL stall_wait_start actual=%b required=0", div_start); end
    end
    tick();
    div_stall = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_full();
    logic [63:0] exp;
    logic accept;
    logic prev = 1'b0;
    int got = 0;
    div_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_d = 32'h40000000 + k; in_e = 32'h3f800000 + k;
      sb.push_back({in_d, in_e});
      tick();
    end
    in_d = 32'h40000004; in_e = 32'h3f800004;
    sb.push_back({in_d, in_e});
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready actual=%b required=0", in_ready); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count actual=%0d required=4", count); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_fifth_held actual=%0d required=4", count); end
    checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL full_busy_start actual=%b required=0", div_start); end
    tick();
    div_busy = 1'b0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      @(negedge clk);
      accept = in_valid && in_ready;
      if (div_start === 1'b1) begin
        exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
        checks++; if (div_d !== exp[63:32]) begin failures++; $display("FAIL full_order_d idx=%0d actual=%h required=%h", got, div_d, exp[63:32]); end
        checks++; if (div_e !== exp[31:0]) begin failures++; $display("FAIL full_order_e idx=%0d actual=%h required=%h", got, div_e, exp[31:0]); end
        checks++; if (prev) begin failures++; $display("FAIL full_back_to_back_start idx=%0d actual=1 required=0", got); end
        got++;
      end
      prev = div_start;
      tick();
      if (accept) in_valid = 1'b0;
    end
    checks++; if (got != 5) begin failures++; $display("FAIL full_issue_count actual=%0d required=5", got); end
    repeat (3) tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_drained actual=%0d required=0", count); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp;
    bit found = 0;
    in_valid = 1'b1; in_d = 32'h41200000; in_e = 32'h40000000;
    sb.push_back({in_d, in_e});
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      if (div_start === 1'b1) found = 1;
    end
    div_busy = 1'b1;
    checks++; if (!found) begin failures++; $display("FAIL rmid_issue actual=none required=div_start"); end
    exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
    checks++; if (div_d !== exp[63:32]) begin failures++; $display("FAIL rmid_div_d actual=%h required=%h", div_d, exp[63:32]); end
    tick();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_d = 32'h42000000 + k; in_e = 32'h3f000000 + k;
      sb.push_back({in_d, in_e});
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL rmid_count_before actual=%0d required=3", count); end
    checks++; if (dut.state !== ST_WAIT) begin failures++; $display("FAIL rmid_state_before actual=%0d required=%0d", dut.state, ST_WAIT); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rmid_count actual=%0d required=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready actual=%b required=1", in_ready); end
    checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL rmid_div_start actual=%b required=0", div_start); end
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL rmid_state actual=%0d required=%0d", dut.state, ST_IDLE); end
    checks++; if (byp_valid !== 1'b0) begin failures++; $display("FAIL rmid_byp_valid actual=%b required=0", byp_valid); end
    tick();
    rst = 1'b1;
    div_busy = 1'b0;
    sb.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL rmid_discarded cycle=%0d actual=%b required=0", c, div_start); end
    end
    tick();
  endtask

`ifdef FDIV_SPECIAL_BYPASS_EN
  task automatic test_bypass();
    logic [31:0] bsb[$];
    logic [31:0] vd[3] = '{32'h3f800000, 32'hbf800000, 32'h00000000};
    logic [31:0] ve[3] = '{32'h00000000, 32'h00000000, 32'h00000000};
    logic [31:0] vq[3] = '{32'h7f800000, 32'hff800000, 32'h7fc00000};
    logic [31:0] exp;
    int got = 0;
    div_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_d = vd[k]; in_e = ve[k];
      bsb.push_back(vq[k]);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL byp_no_start cycle=%0d actual=%b required=0", c, div_start); end
      if (byp_valid === 1'b1) begin
        exp = (bsb.size() != 0) ? bsb.pop_front() : 32'hx;
        checks++; if (byp_q !== exp) begin failures++; $display("FAIL byp_q idx=%0d actual=%h required=%h", got, byp_q, exp); end
        got++;
      end
    end
    checks++; if (got != 3) begin failures++; $display("FAIL byp_count actual=%0d required=3", got); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL byp_drained actual=%0d required=0", count); end
    div_busy = 1'b0;
    tick();
  endtask
`else
  task automatic test_bypass();
    logic [63:0] exp;
    bit found = 0;
    in_valid = 1'b1; in_d = 32'h3f800000; in_e = 32'h00000000;
    sb.push_back({in_d, in_e});
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      checks++; if (byp_valid !== 1'b0) begin failures++; $display("FAIL nobyp_valid cycle=%0d actual=%b required=0", c, byp_valid); end
      if (div_start === 1'b1) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL nobyp_issue actual=none required=div_start"); end
    exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
    checks++; if (div_d !== exp[63:32]) begin failures++; $display("FAIL nobyp_div_d actual=%h required=%h", div_d, exp[63:32]); end
    checks++; if (div_e !== exp[31:0]) begin failures++; $display("FAIL nobyp_div_e actual=%h required=%h", div_e, exp[31:0]); end
    checks++; if (byp_q !== 32'h0) begin failures++; $display("FAIL nobyp_q actual=%h required=0", byp_q); end
    repeat (3) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_full();
    test_reset_mid();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
